// File: rtl/wb_pkg.sv
// Shared Wishbone responder types: the response pipeline stage record
// and the hard upper bound on response latency.
package wb_pkg;

    localparam int WB_MAX_RESP_LATENCY = 8;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        we;
        logic [63:0] data;
    } wb_resp_stage_t;

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-latency response pipeline for wb_mem_responder.
// Ports: clk, rst (async, active-high), i_flush (sync clear),
//        i_stage (entry captured each cycle), o_stage (oldest entry).
module wb_resp_pipe
    import wb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    input  wb_resp_stage_t i_stage,
    output wb_resp_stage_t o_stage
);

    wb_resp_stage_t r_stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_stage;
            for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_stage = r_stage[LATENCY-1];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined slave backed by a DEPTH-word scratch RAM with a
// fixed response latency and an outstanding-request limit.
// Ports: clk, rst (async, active-high); wb_cyc/stb/we/adr/sel/dat_w in;
//        wb_stall/ack/err/dat_r out.
// Macro WB_MEM_RESP_ADDR_CHECK_EN: compare upper address bits against
// BASE_ADDR; mismatching requests are not written and answered with err.
module wb_mem_responder
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 28,
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_w,
    output logic                    wb_stall,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic [DATA_WIDTH-1:0]   wb_dat_r
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

    if (LATENCY < 1 || LATENCY > WB_MAX_RESP_LATENCY) begin : g_bad_lat
        $error("wb_mem_responder: LATENCY out of range");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_bad_out
        $error("wb_mem_responder: MAX_OUTSTANDING out of range");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_dat_r;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_resp;
    logic                  w_rd_ack;
    logic                  w_flush;
    logic                  w_unused;
    wb_resp_stage_t        w_in;
    wb_resp_stage_t        w_out;

    assign w_idx = wb_adr[DEPTH_LOG2-1:0];

`ifdef WB_MEM_RESP_ADDR_CHECK_EN
    assign w_addr_ok = (wb_adr[ADDR_WIDTH-1:DEPTH_LOG2]
                        == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2]);
    assign wb_err    = wb_cyc & w_out.valid & w_out.err;
    assign w_unused  = ^{BASE_ADDR[DEPTH_LOG2-1:0], w_out.data};
`else
    assign w_addr_ok = 1'b1;
    assign wb_err    = 1'b0;
    assign w_unused  = ^{wb_adr[ADDR_WIDTH-1:DEPTH_LOG2], BASE_ADDR,
                         w_out.err, w_out.data};
`endif

    // Responses are masked while cyc is low: an abort squashes the
    // response that would otherwise surface in the abort cycle.
    assign wb_ack   = wb_cyc & w_out.valid & ~w_out.err;
    assign w_rd_ack = wb_ack & ~w_out.we;
    assign w_resp   = wb_ack | wb_err;

    // A retiring response frees its slot in the same cycle.
    assign wb_stall = (r_cnt == CW'(MAX_OUTSTANDING)) & ~w_resp;
    assign w_accept = wb_cyc & wb_stb & ~wb_stall;
    assign w_flush  = ~wb_cyc;

    always_comb begin
        w_in       = '0;
        w_in.valid = w_accept;
        w_in.err   = ~w_addr_ok;
        w_in.we    = wb_we;
        w_in.data  = 64'(r_mem[w_idx]);
    end

    // Memory has no reset; writes commit in the accept cycle.
    always_ff @(posedge clk) begin
        if (w_accept && wb_we && w_addr_ok) begin
            for (int i = 0; i < SW; i++) begin
                if (wb_sel[i]) r_mem[w_idx][8*i +: 8] <= wb_dat_w[8*i +: 8];
            end
        end
    end

    wb_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_stage (w_in),
        .o_stage (w_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!wb_cyc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(w_accept) - CW'(w_resp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_r <= '0;
        end else if (w_rd_ack) begin
            r_dat_r <= w_out.data[DATA_WIDTH-1:0];
        end
    end

    // Read data is presented in the ack cycle and held afterwards.
    assign wb_dat_r = w_rd_ack ? w_out.data[DATA_WIDTH-1:0] : r_dat_r;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: LATENCY=2 instance for data path,
// abort, address and reset cases; LATENCY=4 instance for stall pacing.
module tb_wb_mem_responder;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [27:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic        stall, ack, err;
    logic [31:0] dat_r;

    logic        cyc4, stb4, we4;
    logic [27:0] adr4;
    logic [3:0]  sel4;
    logic [31:0] dat_w4;
    logic        stall4, ack4, err4;
    logic [31:0] dat_r4;

    int checks = 0;
    int errors = 0;
    int idx;
    int n_ack4;
    int acc_at [32];
    logic exp_st, exp_ack;

    wb_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(28), .DEPTH_LOG2(10),
        .LATENCY(2), .MAX_OUTSTANDING(2), .BASE_ADDR(28'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
        .wb_sel(sel), .wb_dat_w(dat_w),
        .wb_stall(stall), .wb_ack(ack), .wb_err(err), .wb_dat_r(dat_r)
    );

    wb_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(28), .DEPTH_LOG2(10),
        .LATENCY(4), .MAX_OUTSTANDING(2), .BASE_ADDR(28'h0)
    ) dut4 (
        .clk(clk), .rst(rst),
        .wb_cyc(cyc4), .wb_stb(stb4), .wb_we(we4), .wb_adr(adr4),
        .wb_sel(sel4), .wb_dat_w(dat_w4),
        .wb_stall(stall4), .wb_ack(ack4), .wb_err(err4), .wb_dat_r(dat_r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic w, input logic [27:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    endtask

    initial begin
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; sel = '0; dat_w = '0;
        cyc4 = 1'b1; stb4 = 1'b0; we4 = 1'b0;
        adr4 = '0; sel4 = 4'hF; dat_w4 = '0;
        #2;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_dat_r", 64'(dat_r), 64'd0);
        check("rst_stall4", 64'(stall4), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: full write then read-after-write
        cyc = 1'b1;
        req(1'b1, 28'h10, 4'hF, 32'hDEADBEEF);
        #2 check("t1_acc_stall", 64'(stall), 64'd0);
        tick();
        req(1'b0, 28'h10, 4'hF, 32'h0);
        #2 check("t1_no_ack_t1", 64'(ack), 64'd0);
        tick();
        stb = 1'b0;
        #2 check("t1_wr_ack", 64'(ack), 64'd1);
        check("t1_wr_dat_r", 64'(dat_r), 64'd0);
        tick();
        #2 check("t1_rd_ack", 64'(ack), 64'd1);
        check("t1_rd_err", 64'(err), 64'd0);
        check("t1_rd_data", 64'(dat_r), 64'hDEADBEEF);
        tick();
        #2 check("t1_ack_pulse", 64'(ack), 64'd0);
        check("t1_dat_hold", 64'(dat_r), 64'hDEADBEEF);
        tick();

        // 2: single byte lane write
        req(1'b1, 28'h10, 4'b0001, 32'h000000AA);
        tick();
        req(1'b0, 28'h10, 4'h0, 32'h0);
        tick();
        stb = 1'b0;
        #2 check("t2_wr_ack", 64'(ack), 64'd1);
        tick();
        #2 check("t2_rd_ack", 64'(ack), 64'd1);
        check("t2_rd_data", 64'(dat_r), 64'hDEADBEAA);
        tick();

        // 4: abort with two reads in flight
        req(1'b0, 28'h10, 4'hF, 32'h0);
        tick();
        req(1'b0, 28'h11, 4'hF, 32'h0);
        #2 check("t4_stall_b", 64'(stall), 64'd0);
        tick();
        cyc = 1'b0; stb = 1'b0;
        #2 check("t4_abort_ack", 64'(ack), 64'd0);
        check("t4_abort_err", 64'(err), 64'd0);
        check("t4_abort_dat", 64'(dat_r), 64'hDEADBEAA);
        tick();
        cyc = 1'b1;
        req(1'b0, 28'h10, 4'hF, 32'h0);
        #2 check("t4_new_stall", 64'(stall), 64'd0);
        check("t4_sq_ack", 64'(ack), 64'd0);
        check("t4_sq_err", 64'(err), 64'd0);
        tick();
        stb = 1'b0;
        #2 check("t4_sq_ack2", 64'(ack), 64'd0);
        tick();
        #2 check("t4_new_ack", 64'(ack), 64'd1);
        check("t4_new_data", 64'(dat_r), 64'hDEADBEAA);
        tick();

        // 5: out-of-window address
        req(1'b1, 28'h0, 4'hF, 32'h12345678);
        tick();
        req(1'b0, 28'h400, 4'hF, 32'h0);
        tick();
        stb = 1'b0;
        #2 check("t5_wr_ack", 64'(ack), 64'd1);
        tick();
`ifdef WB_MEM_RESP_ADDR_CHECK_EN
        #2 check("t5_err", 64'(err), 64'd1);
        check("t5_no_ack", 64'(ack), 64'd0);
        check("t5_dat_keep", 64'(dat_r), 64'hDEADBEAA);
`else
        #2 check("t5_alias_ack", 64'(ack), 64'd1);
        check("t5_no_err", 64'(err), 64'd0);
        check("t5_alias_data", 64'(dat_r), 64'h12345678);
`endif
        tick();
        #2 check("t5_idle_ack", 64'(ack), 64'd0);
        check("t5_idle_err", 64'(err), 64'd0);
        tick();

        // 3: LATENCY=4, MAX_OUTSTANDING=2, stb held for 6 writes + 6 reads
        idx = 0;
        n_ack4 = 0;
        for (int k = 0; k < 30; k++) begin
            exp_st = (idx < 12) && ((k % 4) >= 2);
            if (idx < 12) begin
                stb4   = 1'b1;
                we4    = (idx < 6);
                adr4   = 28'h20 + 28'(idx % 6);
                dat_w4 = 32'hC0DE0000 + 32'(idx % 6);
            end else begin
                stb4 = 1'b0;
                we4  = 1'b0;
            end
            #2;
            if (idx < 12) check("t3_stall", 64'(stall4), 64'(exp_st));
            exp_ack = (k >= 4) && (acc_at[k-4] >= 0);
            check("t3_ack", 64'(ack4), 64'(exp_ack));
            if (exp_ack && acc_at[k-4] >= 6)
                check("t3_rd_data", 64'(dat_r4),
                      64'(32'hC0DE0000 + 32'(acc_at[k-4] - 6)));
            if (ack4) n_ack4++;
            if (idx < 12 && !exp_st) begin
                acc_at[k] = idx;
                idx++;
            end else begin
                acc_at[k] = -1;
            end
            tick();
        end
        check("t3_ack_count", 64'(n_ack4), 64'd12);
        check("t3_err4", 64'(err4), 64'd0);

        // 6: reset with two requests outstanding
        req(1'b0, 28'h10, 4'hF, 32'h0);
        tick();
        req(1'b0, 28'h0, 4'hF, 32'h0);
        tick();
        stb = 1'b0;
        rst = 1'b1;
        #1 check("t6_rst_ack", 64'(ack), 64'd0);
        check("t6_rst_err", 64'(err), 64'd0);
        check("t6_rst_stall", 64'(stall), 64'd0);
        check("t6_rst_dat", 64'(dat_r), 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 check("t6_post_ack", 64'(ack), 64'd0);
            check("t6_post_err", 64'(err), 64'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
